// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM encodings, register map,
// CONFIG field positions and reset values.
package spi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [11:0] OFF_CONFIG  = 12'h000;
  localparam logic [11:0] OFF_DATA    = 12'h004;
  localparam logic [11:0] OFF_STATUS  = 12'h008;
  localparam logic [11:0] OFF_DIVIDER = 12'h00C;

  localparam int CFG_W     = 14;
  localparam int CFG_CPHA  = 0;
  localparam int CFG_CPOL  = 1;
  localparam int CFG_MSB   = 2;
  localparam int CFG_USECS = 3;
  localparam int CFG_ACTHI = 4;
  localparam int CFG_EN    = 5;
  localparam int CFG_FB_LO = 6;
  localparam int CFG_CS_LO = 8;
  localparam int CFG_HOLD  = 11;
  localparam int CFG_RXIE  = 12;
  localparam int CFG_TXIE  = 13;

  localparam logic [CFG_W-1:0] CFG_RESET = 14'h00C;
  localparam int DIV_RESET  = 3;
  localparam int ST_OVF_BIT = 5;

  // Position inside the 32-bit word of the k-th bit on the wire.
  function automatic logic [4:0] frame_bit_idx(input logic [5:0] k,
                                               input logic [5:0] nbits,
                                               input logic       msb_first);
    return 5'(msb_first ? (nbits - 6'd1 - k) : k);
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module spi_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_fifo.sv
// SPI master on the peripheral bus with TX/RX FIFOs, 8..32-bit frames,
// selectable chip select, programmable SCLK divider and level interrupt.
module spi_master_fifo
  import spi_master_pkg::*;
#(
  parameter logic [3:0] ID          = 4'h0,
  parameter int         CLOCK_WIDTH = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         CS_COUNT    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                peripheralEnable,
  input  logic                peripheralBus_we,
  input  logic                peripheralBus_oe,
  output logic                peripheralBus_busy,
  input  logic [15:0]         peripheralBus_address,
  input  logic [3:0]          peripheralBus_byteSelect,
  output logic [31:0]         peripheralBus_dataRead,
  input  logic [31:0]         peripheralBus_dataWrite,
  output logic                requestOutput,
  output logic                irq,
  output logic                spi_en,
  output logic                spi_clk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [CS_COUNT-1:0] spi_cs
);

  localparam int CW = CLOCK_WIDTH + 2;

  logic [CFG_W-1:0]       r_cfg;
  logic [CLOCK_WIDTH-1:0] r_div;
  logic                   r_ovf;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [5:0]             r_bit;
  logic [31:0]            r_tx_word;
  logic [31:0]            r_rx_word;
  logic                   r_sclk;
  logic                   r_mosi;
  logic                   r_cs_active;
  logic                   r_rx_push;

  logic w_cpha, w_cpol, w_msb, w_use_cs, w_act_hi, w_enable, w_hold, w_rx_ie, w_tx_ie;
  logic [1:0] w_fb;
  logic [2:0] w_cs_idx;
  logic [5:0] w_nbits;

  assign w_cpha   = r_cfg[CFG_CPHA];
  assign w_cpol   = r_cfg[CFG_CPOL];
  assign w_msb    = r_cfg[CFG_MSB];
  assign w_use_cs = r_cfg[CFG_USECS];
  assign w_act_hi = r_cfg[CFG_ACTHI];
  assign w_enable = r_cfg[CFG_EN];
  assign w_hold   = r_cfg[CFG_HOLD];
  assign w_rx_ie  = r_cfg[CFG_RXIE];
  assign w_tx_ie  = r_cfg[CFG_TXIE];
  assign w_fb     = r_cfg[CFG_FB_LO +: 2];
  assign w_cs_idx = r_cfg[CFG_CS_LO +: 3];
  assign w_nbits  = ({4'd0, w_fb} + 6'd1) << 3;

  // Bus decode
  logic [11:0] w_off;
  logic        w_sel, w_off_ok, w_rd, w_wr;
  logic        w_wr_cfg, w_wr_data, w_wr_status, w_wr_div;
  logic [31:0] w_lane_mask;
  logic [CFG_W-1:0]       w_cfg_new;
  logic [CLOCK_WIDTH-1:0] w_div_new;

  assign w_off    = peripheralBus_address[11:0];
  assign w_sel    = peripheralEnable & (peripheralBus_address[15:12] == ID);
  assign w_off_ok = (w_off == OFF_CONFIG) | (w_off == OFF_DATA) |
                    (w_off == OFF_STATUS) | (w_off == OFF_DIVIDER);
  assign w_rd     = w_sel & peripheralBus_oe & w_off_ok;
  assign w_wr     = w_sel & peripheralBus_we;
  assign w_wr_cfg    = w_wr & (w_off == OFF_CONFIG);
  assign w_wr_data   = w_wr & (w_off == OFF_DATA);
  assign w_wr_status = w_wr & (w_off == OFF_STATUS);
  assign w_wr_div    = w_wr & (w_off == OFF_DIVIDER);
  assign requestOutput = w_rd;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane_mask[gi*8 +: 8] = {8{peripheralBus_byteSelect[gi]}};
  end

  assign w_cfg_new = (r_cfg & ~w_lane_mask[CFG_W-1:0]) |
                     (peripheralBus_dataWrite[CFG_W-1:0] & w_lane_mask[CFG_W-1:0]);
  assign w_div_new = (r_div & ~w_lane_mask[CLOCK_WIDTH-1:0]) |
                     (peripheralBus_dataWrite[CLOCK_WIDTH-1:0] & w_lane_mask[CLOCK_WIDTH-1:0]);

  // FIFOs
  logic [31:0] w_tx_data, w_rx_data;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic        w_tx_push, w_tx_pop, w_rx_pop;

  assign w_tx_push = w_wr_data & peripheralBus_byteSelect[0];
  assign w_rx_pop  = w_rd & (w_off == OFF_DATA) & ~w_rx_empty;
  assign peripheralBus_busy = w_tx_push & w_tx_full & ~w_tx_pop;

  spi_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_data  (peripheralBus_dataWrite),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  spi_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rx_push),
    .i_data  (r_rx_word),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Bit timing: leading SCLK edge after H cycles, trailing after 2H
  logic [CW-1:0] w_half, w_period;
  logic          w_half_end, w_period_end, w_lead, w_trail, w_sample;
  logic          w_last_bit, w_start, w_chain, w_busy;
  logic [4:0]    w_cur_idx, w_next_idx, w_first_idx;

  assign w_half       = CW'(r_div) + CW'(1);
  assign w_period     = w_half << 1;
  assign w_half_end   = (r_cnt == w_half - CW'(1));
  assign w_period_end = (r_cnt == w_period - CW'(1));
  assign w_lead       = (r_state == ST_SHIFT) & w_half_end;
  assign w_trail      = (r_state == ST_SHIFT) & w_period_end;
  assign w_sample     = w_cpha ? w_trail : w_lead;
  assign w_last_bit   = (r_bit == w_nbits - 6'd1);
  assign w_start      = w_enable & ~w_tx_empty;
  assign w_chain      = w_hold & w_start;
  assign w_tx_pop     = ((r_state == ST_IDLE) & w_start) |
                        ((r_state == ST_END) & w_half_end & w_chain);
  assign w_cur_idx    = frame_bit_idx(r_bit, w_nbits, w_msb);
  assign w_next_idx   = frame_bit_idx(r_bit + 6'd1, w_nbits, w_msb);
  assign w_first_idx  = frame_bit_idx(6'd0, w_nbits, w_msb);
  assign w_busy       = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg <= CFG_RESET;
      r_div <= CLOCK_WIDTH'(DIV_RESET);
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_cfg) r_cfg <= w_cfg_new;
      if (w_wr_div) r_div <= w_div_new;
      if (r_rx_push & w_rx_full & ~w_rx_pop)
        r_ovf <= 1'b1;
      else if (w_wr_status & peripheralBus_byteSelect[0] & peripheralBus_dataWrite[ST_OVF_BIT])
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_tx_word   <= '0;
      r_rx_word   <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs_active <= 1'b0;
      r_rx_push   <= 1'b0;
    end else begin
      r_rx_push <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sclk <= w_cpol;
          r_cnt  <= '0;
        end
        ST_SETUP: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_SHIFT: begin
          if (w_trail) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            if (w_last_bit) begin
              r_state   <= ST_END;
              r_rx_push <= 1'b1;
            end else begin
              r_bit <= r_bit + 6'd1;
              if (!w_cpha) r_mosi <= r_tx_word[w_next_idx];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (w_lead) begin
              r_sclk <= ~r_sclk;
              if (w_cpha) r_mosi <= r_tx_word[w_cur_idx];
            end
          end
          if (w_sample) r_rx_word[w_cur_idx] <= spi_miso;
        end
        ST_END: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (!w_chain) begin
              r_state     <= ST_IDLE;
              r_cs_active <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Frame load, shared by the idle start and the held-CS chain
      if (w_tx_pop) begin
        r_state     <= ST_SETUP;
        r_cs_active <= 1'b1;
        r_tx_word   <= w_tx_data;
        r_rx_word   <= '0;
        r_bit       <= '0;
        r_mosi      <= w_tx_data[w_first_idx];
      end
    end
  end

  always_comb begin
    peripheralBus_dataRead = '1;
    if (w_rd) begin
      case (w_off)
        OFF_CONFIG:  peripheralBus_dataRead = 32'(r_cfg);
        OFF_DATA:    peripheralBus_dataRead = w_rx_empty ? '1 : w_rx_data;
        OFF_STATUS:  peripheralBus_dataRead = {26'd0, r_ovf, w_busy, w_rx_full,
                                               w_rx_empty, w_tx_full, w_tx_empty};
        OFF_DIVIDER: peripheralBus_dataRead = 32'(r_div);
        default:     peripheralBus_dataRead = '1;
      endcase
    end
  end

  for (genvar gi = 0; gi < CS_COUNT; gi++) begin : g_cs
    assign spi_cs[gi] = (r_cs_active & w_use_cs & (w_cs_idx == 3'(gi))) ? w_act_hi : ~w_act_hi;
  end

  assign irq      = (w_rx_ie & ~w_rx_empty) | (w_tx_ie & w_tx_empty);
  assign spi_en   = w_enable;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;

  logic w_unused;
  assign w_unused = ^{peripheralBus_dataWrite, w_lane_mask};

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: register access, SPI modes 0/3,
// held chip select chaining, TX back-pressure, RX overflow and reset.
module tb_spi_master_fifo;

  localparam logic [15:0] A_CFG  = 16'h0000;
  localparam logic [15:0] A_DATA = 16'h0004;
  localparam logic [15:0] A_STAT = 16'h0008;
  localparam logic [15:0] A_DIV  = 16'h000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, we = 1'b0, oe = 1'b0;
  logic [15:0] addr = '0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = '0;
  logic        busy, req, irq, spi_en, spi_clk, spi_mosi, spi_miso;
  logic [31:0] rdata;
  logic [1:0]  spi_cs;
  logic        loop_en = 1'b0, miso_tie = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign spi_miso = loop_en ? spi_mosi : miso_tie;

  spi_master_fifo dut (
    .clk                      (clk),
    .rst                      (rst),
    .peripheralEnable         (en),
    .peripheralBus_we         (we),
    .peripheralBus_oe         (oe),
    .peripheralBus_busy       (busy),
    .peripheralBus_address    (addr),
    .peripheralBus_byteSelect (be),
    .peripheralBus_dataRead   (rdata),
    .peripheralBus_dataWrite  (wdata),
    .requestOutput            (req),
    .irq                      (irq),
    .spi_en                   (spi_en),
    .spi_clk                  (spi_clk),
    .spi_mosi                 (spi_mosi),
    .spi_miso                 (spi_miso),
    .spi_cs                   (spi_cs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    en = 1'b0; we = 1'b0; be = 4'hF;
    $display("[TB] write addr=0x%04h data=0x%08h be=%b", a, d, b);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic r);
    @(negedge clk);
    en = 1'b1; oe = 1'b1; addr = a;
    #1;
    d = rdata;
    r = req;
    @(negedge clk);
    en = 1'b0; oe = 1'b0;
    $display("[TB] read  addr=0x%04h data=0x%08h req=%b", a, d, r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        r;
    logic        prev;
    logic [31:0] bits;
    int edges, first_e, last_e, low0, low1, runs, irq_at, waited;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", {30'd0, spi_cs}, 32'h3);
    check("rst_sclk", {31'd0, spi_clk}, 32'h0);
    check("rst_mosi", {31'd0, spi_mosi}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    bus_read(A_STAT, d, r); check("rst_status", d, 32'h05);
    check("rst_req", {31'd0, r}, 32'h1);
    bus_read(A_CFG, d, r);  check("rst_config", d, 32'h00C);
    bus_read(A_DIV, d, r);  check("rst_divider", d, 32'h3);
    bus_read(A_DATA, d, r); check("empty_rx_read", d, 32'hFFFF_FFFF);
    bus_read(16'h0010, d, r);
    check("bad_off_req", {31'd0, r}, 32'h0);
    check("bad_off_data", d, 32'hFFFF_FFFF);
    bus_read(16'h1008, d, r);
    check("bad_id_req", {31'd0, r}, 32'h0);

    // Byte lanes
    bus_write(A_CFG, 32'h0000_3FDF, 4'b0001);
    bus_read(A_CFG, d, r); check("lane0_config", d, 32'h0DF);
    bus_write(A_CFG, 32'h0000_200C, 4'b0010);
    bus_read(A_CFG, d, r); check("lane1_config", d, 32'h20DF);
    check("irq_tx_empty", {31'd0, irq}, 32'h1);
    bus_write(A_CFG, 32'h0000_000C, 4'b1111);
    #1; check("irq_cleared", {31'd0, irq}, 32'h0);
    bus_write(A_DATA, 32'h77, 4'b0010);
    bus_read(A_STAT, d, r); check("push_needs_lane0", d, 32'h05);

    // Mode 0, MSB first, 8-bit, loopback
    bus_write(A_DIV, 32'h1, 4'hF);
    bus_write(A_CFG, 32'h02C, 4'hF);
    loop_en = 1'b1;
    bus_write(A_DATA, 32'hA5, 4'hF);
    edges = 0; first_e = -1; last_e = -1; low0 = 0; low1 = 0; bits = '0; prev = spi_clk;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (!spi_cs[0]) low0++;
      if (!spi_cs[1]) low1++;
      if (spi_clk && !prev) begin
        if (edges < 8) bits[7-edges] = spi_mosi;
        if (first_e < 0) first_e = c;
        last_e = c;
        edges++;
      end
      prev = spi_clk;
    end
    check("m0_edges", edges, 8);
    check("m0_mosi", bits, 32'hA5);
    check("m0_cs0_low", low0, 36);
    check("m0_cs1_low", low1, 0);
    check("m0_sclk_span", last_e - first_e, 28);
    bus_read(A_DATA, d, r); check("m0_rx", d, 32'h0000_00A5);
    bus_read(A_STAT, d, r); check("m0_status", d, 32'h05);

    // Mode 3, LSB first, 16-bit, MISO tied high
    bus_write(A_CFG, 32'h06B, 4'hF);
    loop_en = 1'b0; miso_tie = 1'b1;
    @(negedge clk);
    check("m3_sclk_idle", {31'd0, spi_clk}, 32'h1);
    bus_write(A_DATA, 32'h1234, 4'hF);
    edges = 0; low0 = 0; bits = '0; prev = spi_clk;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (!spi_cs[0]) low0++;
      if (spi_clk && !prev) begin
        if (edges < 16) bits[edges] = spi_mosi;
        edges++;
      end
      prev = spi_clk;
    end
    check("m3_edges", edges, 16);
    check("m3_mosi", bits, 32'h1234);
    check("m3_cs0_low", low0, 68);
    check("m3_sclk_end", {31'd0, spi_clk}, 32'h1);
    bus_read(A_DATA, d, r); check("m3_rx", d, 32'h0000_FFFF);

    // Held CS on line 1 across three frames, tx-empty interrupt
    loop_en = 1'b1;
    bus_write(A_CFG, 32'h090C, 4'hF);
    bus_write(A_DATA, 32'h11, 4'hF);
    bus_write(A_DATA, 32'h22, 4'hF);
    bus_write(A_DATA, 32'h33, 4'hF);
    bus_write(A_CFG, 32'h292C, 4'hF);
    #1; check("hold_irq_before", {31'd0, irq}, 32'h0);
    low0 = 0; low1 = 0; runs = 0; first_e = -1; irq_at = -1; prev = spi_cs[1];
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (!spi_cs[0]) low0++;
      if (!spi_cs[1]) begin
        low1++;
        if (first_e < 0) first_e = c;
      end
      if (prev && !spi_cs[1]) runs++;
      if (irq && irq_at < 0) irq_at = c;
      prev = spi_cs[1];
    end
    check("hold_cs1_low", low1, 108);
    check("hold_cs1_runs", runs, 1);
    check("hold_cs0_low", low0, 0);
    check("hold_irq_time", irq_at - first_e, 72);
    bus_read(A_DATA, d, r); check("hold_rx0", d, 32'h11);
    bus_read(A_DATA, d, r); check("hold_rx1", d, 32'h22);
    bus_read(A_DATA, d, r); check("hold_rx2", d, 32'h33);

    // TX back-pressure, then RX overflow with six frames unread
    bus_write(A_CFG, 32'h02C, 4'hF);
    bus_write(A_DIV, 32'h4, 4'hF);
    for (int i = 1; i <= 5; i++) bus_write(A_DATA, 32'(i), 4'hF);
    bus_read(A_STAT, d, r); check("txfull_status", d, 32'h16);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = A_DATA; wdata = 32'h6; be = 4'hF;
    #1; check("busy_asserted", {31'd0, busy}, 32'h1);
    waited = 0;
    while (busy && waited < 500) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("busy_released", {31'd0, busy}, 32'h0);
    check("busy_held_long", {31'd0, (waited > 20)}, 32'h1);
    @(negedge clk);
    en = 1'b0; we = 1'b0;
    $display("[TB] stalled write accepted after %0d cycles", waited);
    bus_read(A_STAT, d, r); check("after_stall_status", d, 32'h12);
    for (int i = 0; i < 600; i++) begin
      bus_read(A_STAT, d, r);
      if (!d[4] && d[0]) break;
    end
    check("overflow_status", d, 32'h29);
    for (int i = 1; i <= 4; i++) begin
      bus_read(A_DATA, d, r); check("ovf_rx_word", d, 32'(i));
    end
    bus_read(A_STAT, d, r); check("ovf_sticky", d, 32'h25);
    bus_write(A_STAT, 32'h20, 4'h1);
    bus_read(A_STAT, d, r); check("ovf_w1c", d, 32'h05);

    // Reset in the middle of a frame
    bus_write(A_CFG, 32'h02F, 4'hF);
    bus_write(A_DATA, 32'h5A, 4'hF);
    bus_write(A_DATA, 32'h3C, 4'hF);
    repeat (10) @(negedge clk);
    check("mid_frame_cs", {31'd0, spi_cs[0]}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_cs", {30'd0, spi_cs}, 32'h3);
    check("mid_rst_sclk", {31'd0, spi_clk}, 32'h0);
    check("mid_rst_mosi", {31'd0, spi_mosi}, 32'h0);
    check("mid_rst_irq", {31'd0, irq}, 32'h0);
    bus_read(A_STAT, d, r); check("mid_rst_status", d, 32'h05);
    bus_read(A_CFG, d, r);  check("mid_rst_config", d, 32'h00C);
    bus_read(A_DIV, d, r);  check("mid_rst_divider", d, 32'h3);
    bus_read(A_DATA, d, r); check("mid_rst_rx", d, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
